// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, fetch FSM states and condition-code helpers.
package cpu_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [2:0] NZP_RESET = 3'b010;

    // One-hot {N,Z,P} classification of a register-file write value.
    function automatic logic [2:0] derive_nzp(input logic [15:0] value);
        logic n;
        logic z;
        n = value[15];
        z = (value == 16'h0000);
        return {n, z, !n && !z};
    endfunction

endpackage

// File: rtl/nzp_reg.sv
// Condition-code register; loads the N/Z/P classification of cc_data when cc_we is set.
module nzp_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cc_we,
    input  logic [15:0] cc_data,
    output logic [2:0]  nzp
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzp <= NZP_RESET;
        end else if (cc_we) begin
            nzp <= derive_nzp(cc_data);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/gnt/rvalid fetch FSM, instruction register and BR/JMP redirect.
// Optional FETCH_PERF_CNT_EN adds retired/taken performance counters.
//
// state | meaning
// REQ   | imem_req asserted at pc, waiting for imem_gnt
// WAIT  | request granted, waiting for imem_rvalid
// HOLD  | instr valid, waiting for the consumer's instr_ready
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter logic [15:0] RESET_PC = 16'h3000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [15:0]       imem_rdata,
    output logic [15:0]       instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    input  logic [15:0]       jmp_base,
    input  logic              cc_we,
    input  logic [15:0]       cc_data,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_taken,
`endif
    output logic [2:0]        nzp
);

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       instr_q;
    logic              load_instr;
    logic              accept;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] next_pc;
    logic              br_taken;

    nzp_reg u_nzp_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .cc_we   (cc_we),
        .cc_data (cc_data),
        .nzp     (nzp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        load_instr = 1'b0;
        accept     = 1'b0;
        case (state_q)
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    load_instr = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    accept  = 1'b1;
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    // Redirect uses the nzp value registered before any same-cycle cc_we update.
    assign pc_inc    = pc_q + ADDR_W'(1);
    assign br_target = pc_inc + {{(ADDR_W-9){instr_q[8]}}, instr_q[8:0]};
    assign br_taken  = (instr_q[15:12] == OP_BR) && (|(instr_q[11:9] & nzp));

    always_comb begin
        next_pc = pc_inc;
        if (br_taken) begin
            next_pc = br_target;
        end else if (instr_q[15:12] == OP_JMP) begin
            next_pc = jmp_base[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= PC_RST;
            instr_q <= 16'h0000;
        end else begin
            if (load_instr) instr_q <= imem_rdata;
            if (accept)     pc_q    <= next_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_retired <= 32'd0;
            perf_taken   <= 32'd0;
        end else if (accept) begin
            perf_retired <= perf_retired + 32'd1;
            if (next_pc != pc_inc) perf_taken <= perf_taken + 32'd1;
        end
    end
`endif

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == HOLD);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed fetch/accept sequences, a cycle-level reference model and literal spot checks.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] pc;
    logic [15:0] jmp_base = 16'h0000;
    logic        cc_we = 1'b0;
    logic [15:0] cc_data = 16'h0000;
    logic [2:0]  nzp;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_retired;
    logic [31:0] perf_taken;
`endif

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .jmp_base    (jmp_base),
        .cc_we       (cc_we),
        .cc_data     (cc_data),
`ifdef FETCH_PERF_CNT_EN
        .perf_retired(perf_retired),
        .perf_taken  (perf_taken),
`endif
        .nzp         (nzp)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = requesting, 1 = awaiting data, 2 = holding an instruction.
    // Condition codes are kept as the sign of the last written value.
    int          m_phase;
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    int          m_sign;
    int          m_retired;
    int          m_taken;

    function automatic logic [2:0] sign_to_nzp(input int s);
        return {s < 0, s == 0, s > 0};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase   = 0;
            m_pc      = 16'h3000;
            m_instr   = 16'h0000;
            m_sign    = 0;
            m_retired = 0;
            m_taken   = 0;
        end else begin
            if (m_phase == 0) begin
                if (imem_gnt) m_phase = 1;
            end else if (m_phase == 1) begin
                if (imem_rvalid) begin
                    m_instr = imem_rdata;
                    m_phase = 2;
                end
            end else if (instr_ready) begin
                int          off;
                int          target;
                bit          cond;
                off = int'(m_instr[8:0]);
                if (off >= 256) off = off - 512;
                cond = (m_instr[11] && m_sign < 0) || (m_instr[10] && m_sign == 0) ||
                       (m_instr[9] && m_sign > 0);
                if (m_instr[15:12] == 4'd0 && cond)
                    target = (int'(m_pc) + 1 + off) & 32'hFFFF;
                else if (m_instr[15:12] == 4'd12)
                    target = int'(jmp_base);
                else
                    target = (int'(m_pc) + 1) & 32'hFFFF;
                m_retired++;
                if (target != ((int'(m_pc) + 1) & 32'hFFFF)) m_taken++;
                m_pc    = 16'(target);
                m_phase = 0;
            end
            if (cc_we) begin
                if ($signed(cc_data) < 0)  m_sign = -1;
                else if (cc_data == 16'h0) m_sign = 0;
                else                       m_sign = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("imem_req", {31'd0, imem_req}, {31'd0, m_phase == 0});
            if (m_phase == 0) check("imem_addr", {16'd0, imem_addr}, {16'd0, m_pc});
            check("instr_valid", {31'd0, instr_valid}, {31'd0, m_phase == 2});
            if (m_phase == 2) check("instr", {16'd0, instr}, {16'd0, m_instr});
            check("pc", {16'd0, pc}, {16'd0, m_pc});
            check("nzp", {29'd0, nzp}, {29'd0, sign_to_nzp(m_sign)});
`ifdef FETCH_PERF_CNT_EN
            check("perf_retired", perf_retired, m_retired);
            check("perf_taken", perf_taken, m_taken);
`endif
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        imem_gnt = 0; imem_rvalid = 0; instr_ready = 0; cc_we = 0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // From REQ: gnt sampled on the next edge, rvalid on the one after.
    task automatic fetch(input logic [15:0] word);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 16'hDEAD;
    endtask

    // Slow fetch with stray rvalid and instr_ready outside HOLD; ready stays high into HOLD.
    task automatic fetch_slow_accept(input logic [15:0] word);
        instr_ready = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hBEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        @(negedge clk);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        @(negedge clk);
        imem_rvalid = 1'b0;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    task automatic accept(input logic [15:0] jb, input logic we, input logic [15:0] cd);
        instr_ready = 1'b1;
        jmp_base    = jb;
        cc_we       = we;
        cc_data     = cd;
        @(negedge clk);
        instr_ready = 1'b0;
        cc_we       = 1'b0;
    endtask

    localparam logic [15:0] I_ADD   = 16'h1261;
    localparam logic [15:0] I_BRZ_M2 = 16'h05FE;
    localparam logic [15:0] I_BRN_M2 = 16'h09FE;
    localparam logic [15:0] I_BR_NOP = 16'h01FE;
    localparam logic [15:0] I_JMP   = 16'hC080;
    localparam logic [15:0] I_BRZ_P3 = 16'h0403;

    initial begin
        do_reset();
        check("t1_addr", {16'd0, imem_addr}, 32'h3000);
        check("t1_nzp_reset", {29'd0, nzp}, 32'd2);
        check("t1_instr_reset", {16'd0, instr}, 32'h0);
        // T1/T2: instr_valid low after one edge, high after two.
        imem_gnt = 1'b1;
        @(negedge clk);
        check("t1_valid_c1", {31'd0, instr_valid}, 32'd0);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I_ADD;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("t1_valid_c2", {31'd0, instr_valid}, 32'd1);
        check("t1_instr", {16'd0, instr}, {16'd0, I_ADD});
        accept(16'h0, 1'b0, 16'h0);
        check("t2_addr", {16'd0, imem_addr}, 32'h3001);
        check("t2_nzp", {29'd0, nzp}, 32'd2);
        // Walk to 0x3005 with a positive and then a zero cc write.
        fetch(I_ADD); accept(16'h0, 1'b1, 16'h0005);
        check("cc_pos", {29'd0, nzp}, 32'd1);
        fetch(I_ADD); accept(16'h0, 1'b0, 16'h0);
        fetch_slow_accept(I_ADD);
        check("slow_addr", {16'd0, imem_addr}, 32'h3004);
        fetch(I_ADD); accept(16'h0, 1'b1, 16'h0000);
        check("cc_zero", {29'd0, nzp}, 32'd2);
        // T3
        fetch(I_BRZ_M2); accept(16'h0, 1'b0, 16'h0);
        check("t3_brz", {16'd0, imem_addr}, 32'h3004);
        fetch(I_ADD); accept(16'h0, 1'b0, 16'h0);
        fetch(I_BRN_M2); accept(16'h0, 1'b0, 16'h0);
        check("t3_brn", {16'd0, imem_addr}, 32'h3006);
        // T4
        fetch(I_JMP); accept(16'h4000, 1'b0, 16'h0);
        check("t4_jmp", {16'd0, imem_addr}, 32'h4000);
        fetch(I_JMP); accept(16'hFFFF, 1'b0, 16'h0);
        check("t4_jmp_ffff", {16'd0, imem_addr}, 32'hFFFF);
        fetch(I_ADD); accept(16'h0, 1'b0, 16'h0);
        check("t4_wrap", {16'd0, imem_addr}, 32'h0000);
        fetch(I_BR_NOP); accept(16'h0, 1'b0, 16'h0);
        check("br_nop", {16'd0, imem_addr}, 32'h0001);
        // T5: reset during WAIT, stale rvalid in REQ is dropped.
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("t5_req_in_reset", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 16'h1234;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("t5_valid", {31'd0, instr_valid}, 32'd0);
        check("t5_addr", {16'd0, imem_addr}, 32'h3000);
        // T6: cc_we with BRz accept uses old Z, new N next cycle.
        do_reset();
        fetch(I_BRZ_P3); accept(16'h0, 1'b1, 16'h8000);
        check("t6_addr", {16'd0, imem_addr}, 32'h3004);
        check("t6_nzp", {29'd0, nzp}, 32'd4);
`ifdef FETCH_PERF_CNT_EN
        check("t6_retired", perf_retired, 32'd1);
        check("t6_taken", perf_taken, 32'd1);
`endif
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
